// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operation request handshake plus registered outputs.
// Ports: in_valid/in_ready/op/set_flags/a/b (request), result/out_valid/flags/busy (response).
// master drives requests; slave is the ALU side.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         set_flags;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         out_valid;
    logic [3:0]   flags;
    logic         busy;

    modport master (
        output in_valid, op, set_flags, a, b,
        input  in_ready, result, out_valid, flags, busy
    );

    modport slave (
        input  in_valid, op, set_flags, a, b,
        output in_ready, result, out_valid, flags, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with NZCV flag register, shifts/rotates and a shift-add multiplier.
// Latency: single-cycle ops complete at the accepting edge; MUL completes W edges later.
// Backpressure: in_ready low while the multiplier runs or reset is held; ports: clk, rst_n, bus (slave).
module alu_seq #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_RSB = 4'h2, OP_BIC = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_XNR = 4'h7,
                           OP_LSL = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_ROR = 4'hB,
                           OP_MUL = 4'hC, OP_CMP = 4'hD, OP_MOV = 4'hE, OP_MVN = 4'hF;

    localparam logic [SW-1:0] LAST = SW'(W - 1);

    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t state, state_nxt;

    logic              accept;
    logic [SW-1:0]     sh;
    logic [W:0]        add_w, sub_w, rsb_w, lsl_w, lsr_w;
    logic signed [W:0] asr_w;
    logic [W-1:0]      ror_w;
    logic [W-1:0]      alu_val;
    logic              alu_c, alu_v;
    logic [2*W-1:0]    acc, mcand, mul_sum;
    logic [W-1:0]      mplier;
    logic [SW-1:0]     cnt;
    logic              mul_sf;
    logic              mul_hi_nz;

    // rst_n gates in_ready so the block refuses requests while reset is held.
    assign bus.in_ready = rst_n && (state == IDLE);
    assign bus.busy     = (state == MUL_RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign sh           = bus.b[SW-1:0];

    // Extra bit on each shifter catches the last bit shifted out (0 when sh==0).
    assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign rsb_w = {1'b0, bus.b} - {1'b0, bus.a};
    assign lsl_w = {1'b0, bus.a} << sh;
    assign lsr_w = {bus.a, 1'b0} >> sh;
    assign asr_w = $signed({bus.a, 1'b0}) >>> sh;
    // Triple copy keeps the rotate correct for any sh < 2W without a modulo.
    assign ror_w = W'({bus.a, bus.a, bus.a} >> sh);

    always_comb begin
        alu_val = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_val = add_w[W-1:0];
                alu_c   = add_w[W];
                alu_v   = (bus.a[W-1] == bus.b[W-1]) && (add_w[W-1] != bus.a[W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_val = sub_w[W-1:0];
                alu_c   = sub_w[W];
                alu_v   = (bus.a[W-1] != bus.b[W-1]) && (sub_w[W-1] != bus.a[W-1]);
            end
            OP_RSB: begin
                alu_val = rsb_w[W-1:0];
                alu_c   = rsb_w[W];
                alu_v   = (bus.a[W-1] != bus.b[W-1]) && (rsb_w[W-1] != bus.b[W-1]);
            end
            OP_BIC: alu_val = bus.a & ~bus.b;
            OP_AND: alu_val = bus.a & bus.b;
            OP_OR:  alu_val = bus.a | bus.b;
            OP_XOR: alu_val = bus.a ^ bus.b;
            OP_XNR: alu_val = ~(bus.a ^ bus.b);
            OP_LSL: begin
                alu_val = lsl_w[W-1:0];
                alu_c   = lsl_w[W];
            end
            OP_LSR: begin
                alu_val = lsr_w[W:1];
                alu_c   = lsr_w[0];
            end
            OP_ASR: begin
                alu_val = asr_w[W:1];
                alu_c   = asr_w[0];
            end
            OP_ROR: begin
                alu_val = ror_w;
                alu_c   = (sh != '0) && ror_w[W-1];
            end
            OP_MOV: alu_val = bus.b;
            OP_MVN: alu_val = ~bus.b;
            default: ;
        endcase
    end

    assign mul_sum   = acc + (mplier[0] ? mcand : '0);
    assign mul_hi_nz = (mul_sum[2*W-1:W] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && bus.op == OP_MUL) state_nxt = MUL_RUN;
            MUL_RUN: if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
            bus.flags     <= 4'b0000;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            mul_sf        <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (accept) begin
                if (bus.op == OP_MUL) begin
                    // Operands and set_flags are captured so the requester may move on.
                    acc    <= '0;
                    mcand  <= {{W{1'b0}}, bus.a};
                    mplier <= bus.b;
                    cnt    <= '0;
                    mul_sf <= bus.set_flags;
                end else begin
                    bus.out_valid <= 1'b1;
                    if (bus.op != OP_CMP) bus.result <= alu_val;
                    if (bus.set_flags)
                        bus.flags <= {alu_val[W-1], alu_val == '0, alu_c, alu_v};
                end
            end else if (state == MUL_RUN) begin
                acc    <= mul_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SW'(1);
                if (cnt == LAST) begin
                    bus.out_valid <= 1'b1;
                    bus.result    <= mul_sum[W-1:0];
                    if (mul_sf)
                        bus.flags <= {mul_sum[W-1], mul_sum[W-1:0] == '0, mul_hi_nz, mul_hi_nz};
                end
            end
        end
    end
endmodule
